// File: rtl/rng_health_check.sv
// rng_health_check: online health tests for a pair of random sample streams.
// Runs a repetition count test (RCT) and an adaptive proportion test (APT)
// on rnd1, plus a cross-stream equality test (EQ) between rnd1 and rnd2.
// Each failure flag is sticky and drives the FSM into ALARM.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   rnd1, rnd2   sample pair, OUTPUT_WIDTH bits each
//   valid        rnd1/rnd2 carry a new sample pair this cycle
//   start        pulse: IDLE -> RUN
//   clear        pulse: any state -> IDLE, clears flags and windows_ok
//   running      high while in RUN
//   rct_fail     sticky repetition-count failure
//   apt_fail     sticky adaptive-proportion failure
//   eq_fail      sticky cross-stream equality failure
//   alarm        high while in ALARM
//   window_done  one-cycle pulse per window completed without failure
//   windows_ok   passed-window count, saturating at 16'hFFFF
module rng_health_check #(
  parameter int unsigned OUTPUT_WIDTH = 8,
  parameter int unsigned RCT_CUTOFF   = 4,
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned APT_CUTOFF   = 16,
  parameter int unsigned EQ_CUTOFF    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OUTPUT_WIDTH-1:0] rnd1,
  input  logic [OUTPUT_WIDTH-1:0] rnd2,
  input  logic                    valid,
  input  logic                    start,
  input  logic                    clear,
  output logic                    running,
  output logic                    rct_fail,
  output logic                    apt_fail,
  output logic                    eq_fail,
  output logic                    alarm,
  output logic                    window_done,
  output logic [15:0]             windows_ok
);

  localparam int unsigned IW = $clog2(WINDOW);
  localparam int unsigned CW = $clog2(WINDOW) + 1;
  localparam int unsigned RW = 8;

  localparam logic [RW-1:0] RCT_LIM  = RW'(RCT_CUTOFF);
  localparam logic [CW-1:0] APT_LIM  = CW'(APT_CUTOFF);
  localparam logic [CW-1:0] EQ_LIM   = CW'(EQ_CUTOFF);
  localparam logic [IW-1:0] IDX_LAST = IW'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath state
  logic [OUTPUT_WIDTH-1:0] prev;
  logic [OUTPUT_WIDTH-1:0] ref_val;
  logic [RW-1:0]           rct_cnt;
  logic [CW-1:0]           apt_cnt;
  logic [CW-1:0]           eq_cnt;
  logic [IW-1:0]           idx;
  logic                    first_sample;

  // Combinational next values and control
  logic                    accept;
  logic                    enter_run;
  logic                    win_first;
  logic                    win_last;
  logic [RW-1:0]           rct_nxt;
  logic [CW-1:0]           apt_nxt;
  logic [CW-1:0]           eq_base;
  logic [CW-1:0]           eq_nxt;
  logic                    rct_hit;
  logic                    apt_hit;
  logic                    eq_hit;
  logic                    any_hit;

  // Next counter values for the sample on the inputs; counters saturate at
  // their cutoff so they can never wrap past the trip point.
  always_comb begin
    win_first = (idx == '0);
    win_last  = (idx == IDX_LAST);

    rct_nxt = RW'(1);
    if (!first_sample && (rnd1 == prev)) begin
      rct_nxt = (rct_cnt == RCT_LIM) ? rct_cnt : rct_cnt + RW'(1);
    end

    apt_nxt = CW'(1);
    if (!win_first) begin
      apt_nxt = ((rnd1 == ref_val) && (apt_cnt != APT_LIM)) ? apt_cnt + CW'(1) : apt_cnt;
    end

    eq_base = win_first ? '0 : eq_cnt;
    eq_nxt  = ((rnd1 == rnd2) && (eq_base != EQ_LIM)) ? eq_base + CW'(1) : eq_base;

    rct_hit = (rct_nxt == RCT_LIM);
    apt_hit = (apt_nxt == APT_LIM);
    eq_hit  = (eq_nxt == EQ_LIM);
    any_hit = rct_hit || apt_hit || eq_hit;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear takes priority over start and valid
  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    accept    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            enter_run = 1'b1;
          end
        end
        S_RUN: begin
          if (valid) begin
            accept = 1'b1;
            if (any_hit) begin
              state_d = S_ALARM;
            end
          end
        end
        S_ALARM: begin
          state_d = S_ALARM;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Counters, reference registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      ref_val      <= '0;
      rct_cnt      <= '0;
      apt_cnt      <= '0;
      eq_cnt       <= '0;
      idx          <= '0;
      first_sample <= 1'b0;
      running      <= 1'b0;
      alarm        <= 1'b0;
      rct_fail     <= 1'b0;
      apt_fail     <= 1'b0;
      eq_fail      <= 1'b0;
      window_done  <= 1'b0;
      windows_ok   <= '0;
    end else begin
      running     <= (state_d == S_RUN);
      alarm       <= (state_d == S_ALARM);
      window_done <= 1'b0;
      if (clear) begin
        prev         <= '0;
        ref_val      <= '0;
        rct_cnt      <= '0;
        apt_cnt      <= '0;
        eq_cnt       <= '0;
        idx          <= '0;
        first_sample <= 1'b0;
        rct_fail     <= 1'b0;
        apt_fail     <= 1'b0;
        eq_fail      <= 1'b0;
        windows_ok   <= '0;
      end else if (enter_run) begin
        // windows_ok deliberately survives a restart
        rct_cnt      <= '0;
        apt_cnt      <= '0;
        eq_cnt       <= '0;
        idx          <= '0;
        first_sample <= 1'b1;
        rct_fail     <= 1'b0;
        apt_fail     <= 1'b0;
        eq_fail      <= 1'b0;
      end else if (accept) begin
        prev         <= rnd1;
        first_sample <= 1'b0;
        rct_cnt      <= rct_nxt;
        apt_cnt      <= apt_nxt;
        eq_cnt       <= eq_nxt;
        if (win_first) begin
          ref_val <= rnd1;
        end
        idx <= win_last ? '0 : idx + IW'(1);
        if (rct_hit) rct_fail <= 1'b1;
        if (apt_hit) apt_fail <= 1'b1;
        if (eq_hit)  eq_fail  <= 1'b1;
        if (win_last && !any_hit) begin
          window_done <= 1'b1;
          if (windows_ok != 16'hFFFF) begin
            windows_ok <= windows_ok + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rng_health_check.sv
// Scoreboard bench for rng_health_check: the stimulus process pushes the
// expected post-edge output snapshot for every driven cycle; the monitor pops
// and compares one cycle later at the falling edge.
module tb_rng_health_check;

  typedef struct packed {
    logic        running;
    logic        alarm;
    logic        rct;
    logic        apt;
    logic        eq;
    logic        wdone;
    logic [15:0] wok;
  } obs_t;

  typedef struct packed {
    logic [31:0] id;
    obs_t        o;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rnd1, rnd2;
  logic        valid, start, clear;
  logic        running, rct_fail, apt_fail, eq_fail, alarm, window_done;
  logic [15:0] windows_ok;

  logic        chk = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          next_id = 0;
  item_t       sbq[$];

  rng_health_check #(
    .OUTPUT_WIDTH(8),
    .RCT_CUTOFF(4),
    .WINDOW(64),
    .APT_CUTOFF(16),
    .EQ_CUTOFF(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rnd1(rnd1),
    .rnd2(rnd2),
    .valid(valid),
    .start(start),
    .clear(clear),
    .running(running),
    .rct_fail(rct_fail),
    .apt_fail(apt_fail),
    .eq_fail(eq_fail),
    .alarm(alarm),
    .window_done(window_done),
    .windows_ok(windows_ok)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input logic r, input logic a, input logic rc,
                              input logic ap, input logic e, input logic wd,
                              input logic [15:0] w);
    obs_t o;
    o.running = r; o.alarm = a; o.rct = rc; o.apt = ap; o.eq = e;
    o.wdone = wd; o.wok = w;
    return o;
  endfunction

  function automatic obs_t observe();
    return ex(running, alarm, rct_fail, apt_fail, eq_fail, window_done, windows_ok);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic [7:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 8'hB8;
    return y;
  endfunction

  task automatic compare(input int id, input obs_t got, input obs_t exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL chk%0d got run=%b alarm=%b rct=%b apt=%b eq=%b wdone=%b wok=%0d required run=%b alarm=%b rct=%b apt=%b eq=%b wdone=%b wok=%0d",
               id, got.running, got.alarm, got.rct, got.apt, got.eq, got.wdone, got.wok,
               exp.running, exp.alarm, exp.rct, exp.apt, exp.eq, exp.wdone, exp.wok);
    end
  endtask

  // Drive one cycle (called at a falling edge) and queue its expected result
  task automatic step(input logic v, input logic s, input logic c,
                      input logic [7:0] a, input logic [7:0] b, input obs_t e);
    item_t it;
    valid = v; start = s; clear = c; rnd1 = a; rnd2 = b; chk = 1'b1;
    it.id = 32'(next_id);
    it.o  = e;
    next_id++;
    sbq.push_back(it);
    @(negedge clk);
    valid = 1'b0; start = 1'b0; clear = 1'b0; chk = 1'b0;
  endtask

  // Monitor: any cycle that was driven with an expectation is checked after the edge
  initial begin
    logic  p;
    item_t it;
    forever begin
      @(posedge clk);
      p = chk;
      @(negedge clk);
      if (p) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow got empty queue required an entry");
        end else begin
          it = sbq.pop_front();
          compare(int'(it.id), observe(), it.o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t       idle0, alm;
    logic [7:0] l1, l2, a;

    idle0 = ex(0, 0, 0, 0, 0, 0, 16'd0);
    reset = 1'b1; valid = 1'b0; start = 1'b0; clear = 1'b0;
    rnd1 = '0; rnd2 = '0;
    #23 reset = 1'b0;
    @(negedge clk);

    // Reset state; valid in IDLE ignored
    step(1, 0, 0, 8'h5A, 8'h00, idle0);

    // Repetition test: four identical rnd1 samples
    step(0, 1, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd0));
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 8'h5A, 8'(i), ex(1, 0, 0, 0, 0, 0, 16'd0));
    alm = ex(0, 1, 1, 0, 0, 0, 16'd0);
    step(1, 0, 0, 8'h5A, 8'h03, alm);
    step(1, 0, 0, 8'h11, 8'h22, alm);      // sample in ALARM ignored
    step(0, 1, 0, 8'h00, 8'h00, alm);      // start in ALARM ignored
    step(0, 0, 1, 8'h00, 8'h00, idle0);

    // Full clean window from two LFSR streams, then an EQ trip in window 2
    step(0, 1, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd0));
    l1 = 8'hB4; l2 = 8'h4B;
    for (int i = 1; i <= 64; i++) begin
      step(1, 0, 0, l1, l2, (i == 64) ? ex(1, 0, 0, 0, 0, 1, 16'd1)
                                      : ex(1, 0, 0, 0, 0, 0, 16'd0));
      l1 = lfsr_step(l1);
      l2 = lfsr_step(l2);
    end
    for (int i = 1; i <= 8; i++) begin
      a = 8'h20 + 8'(i);
      step(1, 0, 0, a, a, (i == 8) ? ex(0, 1, 0, 0, 1, 0, 16'd1)
                                   : ex(1, 0, 0, 0, 0, 0, 16'd1));
    end
    // clear and start together in ALARM: clear wins, windows_ok zeroed
    step(0, 1, 1, 8'h00, 8'h00, idle0);
    step(1, 0, 0, 8'h5A, 8'h5A, idle0);
    step(1, 0, 0, 8'h5A, 8'h5A, idle0);

    // Proportion test: rnd1 = 8'h11 on every odd sample
    step(0, 1, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd0));
    for (int n = 1; n <= 31; n++) begin
      a = (n % 2 == 1) ? 8'h11 : 8'h80 + 8'(n);
      step(1, 0, 0, a, ~a, (n == 31) ? ex(0, 1, 0, 1, 0, 0, 16'd0)
                                     : ex(1, 0, 0, 0, 0, 0, 16'd0));
    end
    step(1, 0, 0, 8'h11, 8'h00, ex(0, 1, 0, 1, 0, 0, 16'd0));
    step(0, 0, 1, 8'h00, 8'h00, idle0);

    // Async reset mid-window, then a fresh window from a new start
    step(0, 1, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd0));
    for (int n = 0; n < 30; n++) begin
      a = 8'h40 + 8'(n);
      step(1, 0, 0, a, ~a, ex(1, 0, 0, 0, 0, 0, 16'd0));
    end
    #2 reset = 1'b1;
    #1 compare(9000, observe(), idle0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 8'h40, 8'hBF, idle0);
    step(0, 1, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd0));
    for (int n = 0; n < 64; n++) begin
      a = 8'h40 + 8'(n);
      // start during RUN must not restart the window
      step(1, (n == 10), 0, a, ~a, (n == 63) ? ex(1, 0, 0, 0, 0, 1, 16'd1)
                                             : ex(1, 0, 0, 0, 0, 0, 16'd0));
    end
    step(0, 0, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 0, 0, 16'd1));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL sb_drain got %0d pending required 0", sbq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
